// File: rtl/fetch_queue_issuer_if.sv
// Fetch/issue bundle between the front end, the memory adaptor and the downstream decoder.
// Latency: none; plain wires grouping the handshake and issue signals.
// Backpressure: issue_space_available throttles issue; the memory adaptor paces fetch via insfetch_task_done.
interface fetch_queue_issuer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          request_ins_from_memory_adaptor;
  logic [31:0]   insaddr_to_be_fetched_from_memory_adaptor;
  logic [31:0]   ins_fetched_from_memory_adaptor;
  logic          insfetch_task_done;
  logic          issue_space_available;
  logic          is_issueing;
  logic [31:0]   issue_PC;
  logic [31:0]   predicted_resulting_PC;
  logic [31:0]   full_ins;
  logic          is_compressed_ins;
  logic [CW-1:0] queue_count;

  // Front-end side: drives fetch requests and issued instructions
  modport master (
    output request_ins_from_memory_adaptor, insaddr_to_be_fetched_from_memory_adaptor,
    output is_issueing, issue_PC, predicted_resulting_PC, full_ins, is_compressed_ins, queue_count,
    input  ins_fetched_from_memory_adaptor, insfetch_task_done, issue_space_available
  );

  // Environment side: memory adaptor plus downstream decoder
  modport slave (
    input  request_ins_from_memory_adaptor, insaddr_to_be_fetched_from_memory_adaptor,
    input  is_issueing, issue_PC, predicted_resulting_PC, full_ins, is_compressed_ins, queue_count,
    output ins_fetched_from_memory_adaptor, insfetch_task_done, issue_space_available
  );
endinterface

// File: rtl/fetch_queue_issuer.sv
// Fetch front end: predecodes fetched words for static next-PC and queues them for one-per-cycle issue.
// Latency: fetch done at edge t -> issue registered at edge t+1 at the earliest (no bypass).
// Backpressure: issue waits for issue_space_available; fetch only starts when the queue has room.
module fetch_queue_issuer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter bit          BTFN_EN  = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic [31:0] reset_PC_to,
  input  logic        jalr_just_done,
  input  logic [31:0] jalr_resulting_PC,
  fetch_queue_issuer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN, WAIT_JALR} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic          req, req_nxt;
  logic [31:0]   addr, addr_nxt;
  logic          push, pop;

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_ins  [DEPTH];
  logic [31:0]   q_pred [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          iss_vld;
  logic [31:0]   iss_pc, iss_pred, iss_ins;
  logic          iss_comp;

  logic [31:0]   word, j_imm, b_imm, pred;
  logic [6:0]    opcode;
  logic          word_comp, word_jalr;

  // Predecode the arriving word: length and static next-PC relative to the PC it was fetched from
  always_comb begin
    word      = bus.ins_fetched_from_memory_adaptor;
    opcode    = word[6:0];
    j_imm     = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    b_imm     = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
    word_comp = (word[1:0] != 2'b11);
    word_jalr = !word_comp && (opcode == OP_JALR);
    pred      = fetch_pc + 32'd4;
    if (word_comp)
      pred = fetch_pc + 32'd2;
    else if (opcode == OP_JAL)
      pred = fetch_pc + j_imm;
    else if (BTFN_EN && (opcode == OP_BRANCH) && word[31])
      pred = fetch_pc + b_imm;
  end

  // Fetch FSM next state, request/address and queue push/pop decisions; flush overrides everything
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = req;
    addr_nxt     = addr;
    push         = 1'b0;
    pop          = (count != '0) && bus.issue_space_available && !flush_pipline;
    if (flush_pipline) begin
      fetch_pc_nxt = reset_PC_to;
      case (state)
        // A fetch is in flight: its word must be swallowed before a new request can start.
        // If it completes this very cycle there is nothing left to drain.
        WAIT_MEM, DRAIN: begin
          if (bus.insfetch_task_done) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end else begin
            state_nxt = DRAIN;
          end
        end
        default: begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count < FULL_CNT) begin
            state_nxt = WAIT_MEM;
            req_nxt   = 1'b1;
            addr_nxt  = fetch_pc;
          end
        end
        WAIT_MEM: begin
          if (bus.insfetch_task_done) begin
            push         = 1'b1;
            fetch_pc_nxt = pred;
            req_nxt      = 1'b0;
            state_nxt    = word_jalr ? WAIT_JALR : IDLE;
          end
        end
        DRAIN: begin
          if (bus.insfetch_task_done) begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
        WAIT_JALR: begin
          if (jalr_just_done) begin
            fetch_pc_nxt = jalr_resulting_PC;
            state_nxt    = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, pointers, occupancy and registered issue outputs; everything freezes while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req      <= 1'b0;
      addr     <= 32'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      iss_vld  <= 1'b0;
      iss_pc   <= 32'h0;
      iss_pred <= 32'h0;
      iss_ins  <= 32'h0;
      iss_comp <= 1'b0;
    end else if (rdy_in) begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req      <= req_nxt;
      addr     <= addr_nxt;
      iss_vld  <= pop;
      if (flush_pipline) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (pop) begin
        iss_pc   <= q_pc[rd_ptr];
        iss_pred <= q_pred[rd_ptr];
        iss_ins  <= q_ins[rd_ptr];
        iss_comp <= (q_ins[rd_ptr][1:0] != 2'b11);
      end
    end
  end

  // Queue payload storage; contents of empty slots are don't-care so no reset is needed
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) begin
      q_pc[wr_ptr]   <= fetch_pc;
      q_ins[wr_ptr]  <= word;
      q_pred[wr_ptr] <= pred;
    end
  end

  assign bus.request_ins_from_memory_adaptor           = req;
  assign bus.insaddr_to_be_fetched_from_memory_adaptor = addr;
  assign bus.is_issueing            = iss_vld;
  assign bus.issue_PC               = iss_pc;
  assign bus.predicted_resulting_PC = iss_pred;
  assign bus.full_ins               = iss_ins;
  assign bus.is_compressed_ins      = iss_comp;
  assign bus.queue_count            = count;
endmodule

// File: tb/tb_fetch_queue_issuer.sv
// Directed bench for fetch_queue_issuer: memory responder, issue checks, prediction, JALR stall, flush.
// Latency: outputs sampled on the falling edge, half a cycle after the registering edge.
// Backpressure: issue_space_available is toggled to fill the queue and to hold issue.
module tb_fetch_queue_issuer;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] JAL  = 32'h0200006F;  // jal x0, +0x20
  localparam logic [31:0] BEQ  = 32'hFE000CE3;  // beq x0, x0, -8
  localparam logic [31:0] CLI  = 32'h00004501;  // c.li a0, 0
  localparam logic [31:0] JALR = 32'h00008067;  // jalr x0, 0(x1)

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_pipline, jalr_just_done;
  logic [31:0] reset_PC_to, jalr_resulting_PC;
  logic        seen;
  int          n_vec = 0;
  int          n_err = 0;

  fetch_queue_issuer_if #(.DEPTH(DEPTH)) fq_if ();
  fetch_queue_issuer_if #(.DEPTH(DEPTH)) fq_nt_if ();

  fetch_queue_issuer #(.DEPTH(DEPTH), .RESET_PC(32'h0), .BTFN_EN(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .reset_PC_to(reset_PC_to), .jalr_just_done(jalr_just_done),
    .jalr_resulting_PC(jalr_resulting_PC), .bus(fq_if.master)
  );

  // Same stimulus, branch prediction disabled
  fetch_queue_issuer #(.DEPTH(DEPTH), .RESET_PC(32'h0), .BTFN_EN(1'b0)) dut_nt (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .reset_PC_to(reset_PC_to), .jalr_just_done(jalr_just_done),
    .jalr_resulting_PC(jalr_resulting_PC), .bus(fq_nt_if.master)
  );

  assign fq_nt_if.ins_fetched_from_memory_adaptor = fq_if.ins_fetched_from_memory_adaptor;
  assign fq_nt_if.insfetch_task_done              = fq_if.insfetch_task_done;
  assign fq_nt_if.issue_space_available           = fq_if.issue_space_available;

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, then answer with one done pulse
  task automatic mem_serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
    for (int i = 0; i < 40 && fq_if.request_ins_from_memory_adaptor !== 1'b1; i++)
      @(negedge clk_in);
    chk({tag, "_req"}, 32'(fq_if.request_ins_from_memory_adaptor), 32'd1);
    chk({tag, "_addr"}, fq_if.insaddr_to_be_fetched_from_memory_adaptor, exp_addr);
    if (fq_if.request_ins_from_memory_adaptor === 1'b1) begin
      fq_if.ins_fetched_from_memory_adaptor = word;
      fq_if.insfetch_task_done = 1'b1;
      @(negedge clk_in);
      fq_if.insfetch_task_done = 1'b0;
      fq_if.ins_fetched_from_memory_adaptor = 32'h0;
    end
  endtask

  task automatic exp_issue(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                           input logic [31:0] word, input logic comp);
    chk({tag, "_vld"},  32'(fq_if.is_issueing), 32'd1);
    chk({tag, "_pc"},   fq_if.issue_PC, pc);
    chk({tag, "_pred"}, fq_if.predicted_resulting_PC, npc);
    chk({tag, "_ins"},  fq_if.full_ins, word);
    chk({tag, "_comp"}, 32'(fq_if.is_compressed_ins), 32'(comp));
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0; jalr_just_done = 1'b0;
    reset_PC_to = 32'h0; jalr_resulting_PC = 32'h0;
    fq_if.ins_fetched_from_memory_adaptor = 32'h0;
    fq_if.insfetch_task_done = 1'b0;
    fq_if.issue_space_available = 1'b1;
    repeat (3) @(negedge clk_in);

    // Reset state
    chk("rst_vld",  32'(fq_if.is_issueing), 32'd0);
    chk("rst_pc",   fq_if.issue_PC, 32'h0);
    chk("rst_pred", fq_if.predicted_resulting_PC, 32'h0);
    chk("rst_ins",  fq_if.full_ins, 32'h0);
    chk("rst_comp", 32'(fq_if.is_compressed_ins), 32'd0);
    chk("rst_cnt",  32'(fq_if.queue_count), 32'd0);
    chk("rst_req",  32'(fq_if.request_ins_from_memory_adaptor), 32'd0);
    chk("rst_addr", fq_if.insaddr_to_be_fetched_from_memory_adaptor, 32'h0);
    rst_in = 1'b0;

    // Straight-line NOP stream
    for (int k = 0; k < 3; k++) begin
      mem_serve("nop", 32'(4 * k), NOP);
      @(negedge clk_in);
      exp_issue("nop_iss", 32'(4 * k), 32'(4 * k + 4), NOP, 1'b0);
    end
    chk("nop_cnt", 32'(fq_if.queue_count), 32'd0);

    // Fill the queue with issue blocked, then freeze with rdy_in low, then drain
    fq_if.issue_space_available = 1'b0;
    for (int k = 0; k < 4; k++) mem_serve("fill", 32'(12 + 4 * k), NOP);
    repeat (3) @(negedge clk_in);
    chk("full_req", 32'(fq_if.request_ins_from_memory_adaptor), 32'd0);
    chk("full_cnt", 32'(fq_if.queue_count), 32'd4);
    rdy_in = 1'b0;
    fq_if.issue_space_available = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("frz_vld", 32'(fq_if.is_issueing), 32'd0);
    chk("frz_cnt", 32'(fq_if.queue_count), 32'd4);
    rdy_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      exp_issue("drain", 32'(12 + 4 * k), 32'(16 + 4 * k), NOP, 1'b0);
      if (k == 1) begin
        chk("resume_req",  32'(fq_if.request_ins_from_memory_adaptor), 32'd1);
        chk("resume_addr", fq_if.insaddr_to_be_fetched_from_memory_adaptor, 32'h1C);
      end
    end
    @(negedge clk_in);
    chk("drain_end", 32'(fq_if.is_issueing), 32'd0);

    // Prediction: JAL, backward branch (both BTFN settings), compressed
    mem_serve("jal", 32'h1C, JAL);
    @(negedge clk_in);
    exp_issue("jal_iss", 32'h1C, 32'h3C, JAL, 1'b0);
    mem_serve("beq", 32'h3C, BEQ);
    @(negedge clk_in);
    exp_issue("beq_iss", 32'h3C, 32'h34, BEQ, 1'b0);
    chk("beq_nt_pred", fq_nt_if.predicted_resulting_PC, 32'h40);
    chk("beq_nt_addr", fq_nt_if.insaddr_to_be_fetched_from_memory_adaptor, 32'h40);
    mem_serve("cli", 32'h34, CLI);
    @(negedge clk_in);
    exp_issue("cli_iss", 32'h34, 32'h36, CLI, 1'b1);

    // JALR stalls fetch until the target is resolved
    mem_serve("jalr", 32'h36, JALR);
    @(negedge clk_in);
    exp_issue("jalr_iss", 32'h36, 32'h3A, JALR, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      seen |= fq_if.request_ins_from_memory_adaptor;
    end
    chk("jalr_stall", 32'(seen), 32'd0);
    jalr_just_done = 1'b1;
    jalr_resulting_PC = 32'h100;
    @(negedge clk_in);
    jalr_just_done = 1'b0;
    mem_serve("tgt", 32'h100, NOP);
    @(negedge clk_in);
    exp_issue("tgt_iss", 32'h100, 32'h104, NOP, 1'b0);

    // Flush while a fetch is outstanding: the late word is drained, never issued
    flush_pipline = 1'b1;
    reset_PC_to = 32'h200;
    @(negedge clk_in);
    flush_pipline = 1'b0;
    chk("drn_req",  32'(fq_if.request_ins_from_memory_adaptor), 32'd1);
    chk("drn_addr", fq_if.insaddr_to_be_fetched_from_memory_adaptor, 32'h104);
    chk("drn_cnt",  32'(fq_if.queue_count), 32'd0);
    seen = fq_if.is_issueing;
    repeat (2) begin
      @(negedge clk_in);
      seen |= fq_if.is_issueing;
    end
    fq_if.ins_fetched_from_memory_adaptor = 32'h00100093;
    fq_if.insfetch_task_done = 1'b1;
    @(negedge clk_in);
    seen |= fq_if.is_issueing;
    fq_if.insfetch_task_done = 1'b0;
    fq_if.ins_fetched_from_memory_adaptor = 32'h0;
    chk("drn_done_req", 32'(fq_if.request_ins_from_memory_adaptor), 32'd0);
    @(negedge clk_in);
    seen |= fq_if.is_issueing;
    chk("drn_no_issue", 32'(seen), 32'd0);
    chk("drn_cnt2", 32'(fq_if.queue_count), 32'd0);
    mem_serve("flush", 32'h200, NOP);
    @(negedge clk_in);
    exp_issue("flush_iss", 32'h200, 32'h204, NOP, 1'b0);

    // Flush in the same cycle as a pop and a push
    fq_if.issue_space_available = 1'b0;
    mem_serve("pre", 32'h204, NOP);
    for (int i = 0; i < 10 && fq_if.request_ins_from_memory_adaptor !== 1'b1; i++)
      @(negedge clk_in);
    chk("coll_addr", fq_if.insaddr_to_be_fetched_from_memory_adaptor, 32'h208);
    chk("coll_cnt0", 32'(fq_if.queue_count), 32'd1);
    fq_if.ins_fetched_from_memory_adaptor = NOP;
    fq_if.insfetch_task_done = 1'b1;
    fq_if.issue_space_available = 1'b1;
    flush_pipline = 1'b1;
    reset_PC_to = 32'h300;
    @(negedge clk_in);
    fq_if.insfetch_task_done = 1'b0;
    flush_pipline = 1'b0;
    chk("coll_vld", 32'(fq_if.is_issueing), 32'd0);
    chk("coll_cnt", 32'(fq_if.queue_count), 32'd0);
    chk("coll_req", 32'(fq_if.request_ins_from_memory_adaptor), 32'd0);
    @(negedge clk_in);
    chk("coll_vld2", 32'(fq_if.is_issueing), 32'd0);
    mem_serve("post", 32'h300, NOP);
    @(negedge clk_in);
    exp_issue("post_iss", 32'h300, 32'h304, NOP, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
